data_mem_bank: RTL and testbench
================================

// Module: data_mem_bank
// PURPOSE
//  Parametrised data memory for the MEM stage. Byte-addressed, word-organised.
//  - Byte-enable writes and a configurable pipelined read latency.
//  - Alignment and range checking, reported as an error response.
//  - After every reset, a clear state machine zeroes the whole array before
//    accepting requests. One request per cycle, one response per accepted request.
// PARAMETERS
//  DATA_W        32  word width in bits; multiple of 8; DATA_W/8 is a power of 2
//  ADDR_W        32  request address width in bits
//  DEPTH         16  number of words; power of 2, >=2
//  RD_LAT        1   cycles from request acceptance to rsp_valid; legal range 1..4
//  CLEAR_ON_RST  1   1: zero all words after reset; 0: skip the clear
// PORTS
//  clk        in   1         clock; everything is updated on the rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept a request this cycle
//  req_we     in   1         write request
//  req_re     in   1         read request
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables; bit i selects wdata[8i+7:8i]
//  rsp_valid  out  1         response valid, one cycle per response
//  rsp_rdata  out  DATA_W    read data; 0 when rsp_valid=0, for writes, and on error
//  rsp_err    out  1         response is an error; 0 when rsp_valid=0
//  init_done  out  1         clear has finished; block is in RUN
// BEHAVIOUR
//  Constants: OFF_W=$clog2(DATA_W/8), IDX_W=$clog2(DEPTH).
//  Word index idx = req_addr[OFF_W+IDX_W-1:OFF_W].
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
//    Reset empties the response pipeline and forces the FSM to INIT.
//    Reset mid-operation discards all in-flight responses; none are emitted.
//  FSM states: INIT, RUN.
//   INIT: clear counter starts at 0 and writes 0 to word[counter] each cycle.
//     After word DEPTH-1 is written -> RUN. INIT lasts exactly DEPTH cycles.
//     With CLEAR_ON_RST=0, INIT lasts 1 cycle and array contents are retained.
//     Requests are not accepted in INIT (req_ready=0).
//   RUN: req_ready=1 and init_done=1, held until the next rst.
//  Accept = req_valid & req_ready & (req_we | req_re).
//    A request with req_valid=1 and we=re=0 is ignored and gets no response.
//  Error = (we & re) | (req_addr[OFF_W-1:0] != 0) | (req_addr[ADDR_W-1:OFF_W+IDX_W] != 0).
//    An error access does not modify the array.
//    Its response has rsp_err=1 and rsp_rdata=0.
//  Write (no error): at the acceptance edge, word[idx] byte i <= wdata byte i
//    for every i with be[i]=1. Bytes with be[i]=0 are unchanged.
//    be=0 is legal: the array is unchanged and a response is still produced.
//  Read (no error): word[idx] is sampled at the acceptance edge.
//    The sample includes every write accepted in earlier cycles.
//    be is ignored for reads; rdata is always the full word.
//  Response: rsp_valid pulses exactly RD_LAT cycles after the acceptance edge.
//    Responses come out in request order.
//    Back-to-back requests give back-to-back responses (full throughput).
//    There is no response backpressure.
//  Read-after-write: a read of word X accepted the cycle after a write to X
//    returns the new data.
// TESTING
//  1. rst 1 cycle, DEPTH=16 -> init_done=0 and req_ready=0 for 16 cycles, then 1;
//     a read of each address 0x00..0x3C returns 0.
//  2. write 0x0000_0008 <= 0xDEADBEEF (be=4'hF), then read 0x08 -> after RD_LAT=1
//     rsp_rdata=0xDEADBEEF, rsp_err=0; the write's own response has rdata=0.
//  3. be=4'b0101, wdata=0x11223344 over 0xDEADBEEF at addr 0x08 -> read returns 0xDE22BE44.
//  4. read addr 0x02 (misaligned), 0x40 (out of range), we=re=1 -> rsp_err=1, rdata=0,
//     and memory is unchanged.
//  5. RD_LAT=3: reads of 0x00,0x04,0x08 on consecutive cycles -> three consecutive
//     rsp_valid cycles starting 3 cycles after the first read, data in order.
//  6. rst while 2 reads are in flight -> no rsp_valid afterwards; INIT re-runs and
//     previously written words read back as 0 (CLEAR_ON_RST=1) or retained (=0).

Source files
------------

// File: rtl/data_mem_bank.sv
// Byte-addressed, word-organised data memory for the MEM stage: byte-enable writes,
// pipelined reads, alignment/range error responses and a post-reset clear sequence.
module data_mem_bank #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 16,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_re,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [IDX_W-1:0]   idx;
    logic               misalign, out_of_range, req_err;
    logic               accept, do_write, do_read;
    logic [DATA_W-1:0]  rd_word;

    logic [RD_LAT-1:0]  pipe_valid;
    logic [RD_LAT-1:0]  pipe_err;
    logic [DATA_W-1:0]  pipe_data [RD_LAT];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                clr_cnt <= clr_cnt + IDX_W'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state_q)
            INIT: begin
                if (CLEAR_ON_RST == 0 || clr_cnt == IDX_W'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_d = INIT;
        endcase
    end

    // ---------------- request decode ----------------
    assign idx          = req_addr[OFF_W +: IDX_W];
    assign misalign     = |(req_addr & OFF_MASK);
    assign out_of_range = |(req_addr >> (OFF_W + IDX_W));
    assign req_err      = (req_we & req_re) | misalign | out_of_range;
    assign accept       = req_valid & req_ready & (req_we | req_re);
    assign do_write     = accept & req_we & ~req_err;
    assign do_read      = accept & req_re & ~req_err;
    assign rd_word      = do_read ? mem[idx] : '0;

    // NOTE: the array has no reset term; zeroing is done one word per cycle by the INIT state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT && CLEAR_ON_RST != 0) begin
                mem[clr_cnt] <= '0;
            end else if (do_write) begin
                for (int b = 0; b < NB; b++)
                    if (req_be[b])
                        mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < RD_LAT; i++)
                pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    // Payload travels unreset beside the valid bits; outputs are gated by valid.
    always_ff @(posedge clk) begin
        pipe_data[0] <= rd_word;
        pipe_err[0]  <= req_err & accept;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_err[i]  <= pipe_err[i-1];
        end
    end

    assign rsp_valid = pipe_valid[RD_LAT-1];
    assign rsp_err   = pipe_valid[RD_LAT-1] & pipe_err[RD_LAT-1];
    assign rsp_rdata = pipe_valid[RD_LAT-1] ? pipe_data[RD_LAT-1] : '0;

endmodule

// File: tb/tb_data_mem_bank.sv
// Scoreboard bench for data_mem_bank: two instances (RD_LAT=1 with clear, RD_LAT=3
// without clear) share one stimulus stream; a per-instance model predicts every response.
module tb_data_mem_bank;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_re;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        ready_w [2];
    logic        valid_w [2];
    logic        err_w   [2];
    logic        idn_w   [2];
    logic [31:0] rdata_w [2];

    int lat      [2] = '{1, 3};
    int init_len [2] = '{16, 1};
    int clr      [2] = '{1, 0};

    exp_t        q  [2][$];
    logic [31:0] mm [2][16];
    logic [3:0]  kn [2][16];

    int cyc       = 0;
    int rst_mark  = 0;
    bit have_rst  = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    data_mem_bank #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_w[0]),
        .req_we(req_we), .req_re(req_re), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(valid_w[0]), .rsp_rdata(rdata_w[0]),
        .rsp_err(err_w[0]), .init_done(idn_w[0])
    );

    data_mem_bank #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LAT(3), .CLEAR_ON_RST(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_w[1]),
        .req_we(req_we), .req_re(req_re), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(valid_w[1]), .rsp_rdata(rdata_w[1]),
        .rsp_err(err_w[1]), .init_done(idn_w[1])
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rst_mark <= cyc + 1;
            have_rst <= 1'b1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Monitor: handshake state and every presented response, sampled mid-cycle.
    always @(negedge clk) begin
        if (have_rst) begin
            for (int p = 0; p < 2; p++) begin
                exp_t e;
                if (!rst) begin
                    check($sformatf("req_ready_%0d", p), 32'(ready_w[p]), 32'(cyc - rst_mark >= init_len[p]));
                    check($sformatf("init_done_%0d", p), 32'(idn_w[p]), 32'(cyc - rst_mark >= init_len[p]));
                end
                while (q[p].size() > 0 && q[p][0].due < cyc) begin
                    e = q[p].pop_front();
                    check($sformatf("rsp_missing_%0d", p), 32'(0), 32'(1));
                end
                if (valid_w[p]) begin
                    if (q[p].size() == 0) begin
                        check($sformatf("rsp_spurious_%0d", p), 32'(1), 32'(0));
                    end else begin
                        e = q[p].pop_front();
                        check($sformatf("rsp_time_%0d", p), 32'(cyc), 32'(e.due));
                        check($sformatf("rsp_rdata_%0d", p), rdata_w[p] & e.mask, e.data & e.mask);
                        check($sformatf("rsp_err_%0d", p), 32'(err_w[p]), 32'(e.err));
                    end
                end else begin
                    check($sformatf("idle_rdata_%0d", p), rdata_w[p], 32'h0);
                    check($sformatf("idle_err_%0d", p), 32'(err_w[p]), 32'h0);
                end
            end
        end
    end

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            q[p].delete();
            if (clr[p] != 0)
                for (int w = 0; w < 16; w++) begin
                    mm[p][w] = 32'h0;
                    kn[p][w] = 4'hF;
                end
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_re    = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drive one request for one cycle and record what each instance must answer.
    task automatic issue(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        logic       err;
        int         idx;
        exp_t       e;
        req_valid = 1'b1;
        req_we    = we;
        req_re    = re;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (we || re) begin
            err = (we && re) || (addr[1:0] != 2'b00) || (addr[31:6] != 26'h0);
            idx = int'(addr[5:2]);
            for (int p = 0; p < 2; p++) begin
                e.due  = cyc + lat[p];
                e.err  = err;
                e.data = 32'h0;
                e.mask = 32'hFFFF_FFFF;
                if (!err && re) begin
                    e.data = mm[p][idx];
                    e.mask = byte_mask(kn[p][idx]);
                end
                if (!err && we)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) begin
                            mm[p][idx][8*b +: 8] = wdata[8*b +: 8];
                            kn[p][idx][b]        = 1'b1;
                        end
                q[p].push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_re    = 1'b0;
        rst       = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        for (int p = 0; p < 2; p++)
            for (int w = 0; w < 16; w++) begin
                mm[p][w] = 32'h0;
                kn[p][w] = 4'h0;
            end
        @(posedge clk); #1;
        do_reset(2);
        repeat (20) idle();

        // Every word reads back zero after the clear.
        for (int w = 0; w < 16; w++) issue(1'b0, 1'b1, 32'(w * 4), 32'h0, 4'h0);

        // Full write, partial write, read-after-write.
        issue(1'b1, 1'b0, 32'h08, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 1'b1, 32'h08, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 32'h08, 32'h1122_3344, 4'b0101);
        issue(1'b0, 1'b1, 32'h08, 32'h0, 4'hF);

        // Error accesses leave memory untouched.
        issue(1'b0, 1'b1, 32'h02, 32'h0, 4'hF);
        issue(1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
        issue(1'b1, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF);
        issue(1'b1, 1'b0, 32'h0A, 32'hFFFF_FFFF, 4'hF);
        issue(1'b1, 1'b0, 32'h8000_0008, 32'hFFFF_FFFF, 4'hF);
        issue(1'b0, 1'b1, 32'h08, 32'h0, 4'h0);
        repeat (2) idle();

        // Back-to-back reads.
        issue(1'b0, 1'b1, 32'h00, 32'h0, 4'h0);
        issue(1'b0, 1'b1, 32'h04, 32'h0, 4'h0);
        issue(1'b0, 1'b1, 32'h08, 32'h0, 4'h0);

        // be=0 write, and a valid request with neither we nor re.
        issue(1'b1, 1'b0, 32'h10, 32'h5555_AAAA, 4'h0);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);

        // Randomised traffic with occasional gaps and bad addresses.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic we, re;
            logic [31:0] addr;
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
                idle();
            end else if (r == 1) begin
                issue(1'b0, 1'b0, 32'(4 * $urandom_range(0, 15)), $urandom, 4'hF);
            end else begin
                we = 1'($urandom);
                re = !we;
                if ($urandom_range(0, 15) == 0) begin
                    we = 1'b1;
                    re = 1'b1;
                end
                addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'(4 * $urandom_range(0, 15));
                issue(we, re, addr, $urandom, 4'($urandom));
            end
        end
        repeat (8) idle();

        // Reset with two reads in flight: nothing may emerge afterwards.
        issue(1'b1, 1'b0, 32'h14, 32'hCAFE_F00D, 4'hF);
        issue(1'b1, 1'b0, 32'h18, 32'h0BAD_F00D, 4'hF);
        repeat (4) idle();
        issue(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        issue(1'b0, 1'b1, 32'h18, 32'h0, 4'h0);
        do_reset(1);
        repeat (20) idle();
        for (int w = 0; w < 16; w++) issue(1'b0, 1'b1, 32'(w * 4), 32'h0, 4'h0);
        repeat (10) idle();

        check("queue_drained", 32'(q[0].size() + q[1].size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
